// File: rtl/wb_uart_master.sv
// wb_uart_master
// ---------------------------------------------------------------------------
// Serial (RS-232, 8N1) to Wishbone bus master. A host sends framed commands:
//   write : 0x57, ADR_W/8 address bytes, DAT_W/8 data bytes (MSB byte first)
//   read  : 0x52, ADR_W/8 address bytes                     (MSB byte first)
// Each command runs one single Wishbone cycle. The reply is a status byte
// (0x06 ack, 0x15 bus error, 0x18 timeout) followed, for an acknowledged
// read, by DAT_W/8 read-data bytes MSB first.
//
// Optional feature macro: WB_UART_MASTER_TIMEOUT_EN
//   defined   : a bus cycle with no ack/err is aborted after TIMEOUT cycles
//               and answered with 0x18.
//   undefined : a bus cycle waits indefinitely for ack_i/err_i.
//
// Ports
//   clk_i         system clock
//   reset_n_i     asynchronous active-low reset
//   rs232_rxd_i   UART receive (asynchronous, idle high)
//   rs232_txd_o   UART transmit (idle high)
//   adr_o/dat_o   Wishbone address / write data, stable through the cycle
//   dat_i         Wishbone read data
//   we_o          write enable (only meaningful while stb_o is high)
//   sel_o         byte selects, all ones while stb_o is high, else zero
//   stb_o/cyc_o   strobe and cycle (identical)
//   ack_i/err_i   slave terminations; ack wins when both are high
//   parser_state  debug view of the command parser state (p_state_t encoding)
//
// Handshake: a Wishbone cycle is open while stb_o is high; it terminates on
// the first rising clock edge at which ack_i or err_i is sampled high (or
// the timeout expires), and stb_o drops on that same edge.
// ---------------------------------------------------------------------------
module wb_uart_master #(
  parameter int CLK_DIV = 868,
  parameter int ADR_W   = 16,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               rs232_rxd_i,
  output logic               rs232_txd_o,
  output logic [ADR_W-1:0]   adr_o,
  output logic [DAT_W-1:0]   dat_o,
  input  logic [DAT_W-1:0]   dat_i,
  output logic               we_o,
  output logic [DAT_W/8-1:0] sel_o,
  output logic               stb_o,
  output logic               cyc_o,
  input  logic               ack_i,
  input  logic               err_i,
  output logic [2:0]         parser_state
);

  localparam int ADR_B = ADR_W / 8;
  localparam int DAT_B = DAT_W / 8;
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [2:0]       ADR_LAST = 3'(ADR_B - 1);
  localparam logic [2:0]       DAT_LAST = 3'(DAT_B - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] ST_ACK    = 8'h06;
  localparam logic [7:0] ST_ERR    = 8'h15;
  localparam logic [7:0] ST_TMO    = 8'h18;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_ADDR = 3'd1,
    P_DATA = 3'd2,
    P_BUS  = 3'd3,
    P_RESP = 3'd4
  } p_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } r_state_t;

  // -------------------------------------------------------------------------
  // RX synchroniser. rx_prev is one more stage so a falling edge is detected
  // only on already-synchronised values.
  // -------------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rs232_rxd_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // -------------------------------------------------------------------------
  // UART receiver
  // -------------------------------------------------------------------------
  r_state_t         r_state, r_state_d;
  logic [CNT_W-1:0] r_cnt, r_cnt_d;
  logic [2:0]       r_bit, r_bit_d;
  logic [7:0]       r_sh, r_sh_d;
  logic             r_valid, r_valid_d;   // one-cycle pulse: r_sh holds a good byte
  logic             r_ferr, r_ferr_d;     // one-cycle pulse: stop bit sampled low

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= r_state_d;
      r_cnt   <= r_cnt_d;
      r_bit   <= r_bit_d;
      r_sh    <= r_sh_d;
      r_valid <= r_valid_d;
      r_ferr  <= r_ferr_d;
    end
  end

  always_comb begin
    r_state_d = r_state;
    r_cnt_d   = r_cnt + 1'b1;
    r_bit_d   = r_bit;
    r_sh_d    = r_sh;
    r_valid_d = 1'b0;
    r_ferr_d  = 1'b0;
    case (r_state)
      R_IDLE: begin
        r_cnt_d = '0;
        if (!rx_s2 && rx_prev) r_state_d = R_START;
      end
      R_START: begin
        // Mid start bit: a glitch that is already high again is discarded.
        if (r_cnt == BIT_HALF) begin
          r_cnt_d   = '0;
          r_bit_d   = '0;
          r_state_d = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (r_cnt == BIT_LAST) begin
          r_cnt_d = '0;
          r_sh_d  = {rx_s2, r_sh[7:1]};
          r_bit_d = r_bit + 3'd1;
          if (r_bit == 3'd7) r_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (r_cnt == BIT_LAST) begin
          r_cnt_d   = '0;
          r_state_d = R_IDLE;
          if (rx_s2) r_valid_d = 1'b1;
          else       r_ferr_d  = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus timeout
  // -------------------------------------------------------------------------
  logic timeout_hit;

`ifdef WB_UART_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Held at zero outside BUS, so it always starts from zero on BUS entry.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)            to_cnt <= '0;
    else if (stb_o == 1'b0)    to_cnt <= '0;
    else                       to_cnt <= to_cnt + 1'b1;
  end

  // Fires in the TIMEOUT-th cycle of the strobe, so stb_o is high exactly
  // TIMEOUT cycles.
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
`else
  // No timeout in this build; TIMEOUT has no effect.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // -------------------------------------------------------------------------
  // Command parser FSM
  // -------------------------------------------------------------------------
  p_state_t         p_state, p_state_d;
  logic             is_write;
  logic [2:0]       b_cnt;
  logic [ADR_W-1:0] adr_q;
  logic [DAT_W-1:0] dat_q;
  logic [DAT_W-1:0] rd_q;
  logic [7:0]       status_q;
  logic             term;
  logic [7:0]       term_status;
  logic             is_cmd;

  // Transmitter state
  logic             txd_q;
  logic             tx_busy;
  logic [8:0]       tx_sh;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [2:0]       resp_left;
  logic             tx_bit_end;
  logic             tx_last_done;

  assign is_cmd       = (r_sh == CMD_WRITE) || (r_sh == CMD_READ);
  assign tx_bit_end   = tx_busy && (tx_cnt == BIT_LAST);
  assign tx_last_done = tx_bit_end && (tx_bit == 4'd9) && (resp_left == 3'd0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) p_state <= P_IDLE;
    else            p_state <= p_state_d;
  end

  always_comb begin
    p_state_d   = p_state;
    term        = 1'b0;
    term_status = ST_ACK;
    case (p_state)
      P_IDLE: begin
        if (r_valid && is_cmd) p_state_d = P_ADDR;
      end
      P_ADDR: begin
        if (r_ferr) p_state_d = P_IDLE;
        else if (r_valid && (b_cnt == ADR_LAST))
          p_state_d = is_write ? P_DATA : P_BUS;
      end
      P_DATA: begin
        if (r_ferr) p_state_d = P_IDLE;
        else if (r_valid && (b_cnt == DAT_LAST)) p_state_d = P_BUS;
      end
      P_BUS: begin
        if (ack_i) begin
          term        = 1'b1;
          term_status = ST_ACK;
        end else if (err_i) begin
          term        = 1'b1;
          term_status = ST_ERR;
        end else if (timeout_hit) begin
          term        = 1'b1;
          term_status = ST_TMO;
        end
        if (term) p_state_d = P_RESP;
      end
      P_RESP: begin
        if (tx_last_done) p_state_d = P_IDLE;
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  // Command field capture and bus result latching
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      is_write <= 1'b0;
      b_cnt    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      rd_q     <= '0;
      status_q <= '0;
    end else begin
      case (p_state)
        P_IDLE: begin
          if (r_valid && is_cmd) begin
            is_write <= (r_sh == CMD_WRITE);
            b_cnt    <= '0;
          end
        end
        P_ADDR: begin
          if (r_valid) begin
            // Shift in MSB-first: the low ADR_W bits of {adr_q, byte}.
            adr_q <= ADR_W'({adr_q, r_sh});
            b_cnt <= (b_cnt == ADR_LAST) ? 3'd0 : b_cnt + 3'd1;
          end
        end
        P_DATA: begin
          if (r_valid) begin
            dat_q <= DAT_W'({dat_q, r_sh});
            b_cnt <= (b_cnt == DAT_LAST) ? 3'd0 : b_cnt + 3'd1;
          end
        end
        P_BUS: begin
          if (term) begin
            status_q <= term_status;
            if (ack_i && !is_write) rd_q <= dat_i;
          end
        end
        P_RESP: begin
          // Present the next read-data byte at the top of rd_q.
          if (tx_bit_end && (tx_bit == 4'd9) && (resp_left != 3'd0))
            rd_q <= rd_q << 8;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // UART transmitter. The status byte is loaded in the first RESP cycle, so
  // its start bit begins one edge after stb_o falls. Following bytes are
  // loaded in the last cycle of the previous stop bit, leaving no gap.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      txd_q     <= 1'b1;
      tx_busy   <= 1'b0;
      tx_sh     <= '1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      resp_left <= '0;
    end else begin
      if (p_state == P_BUS && term)
        resp_left <= (ack_i && !is_write) ? 3'(DAT_B) : 3'd0;

      if (p_state == P_RESP) begin
        if (!tx_busy) begin
          txd_q   <= 1'b0;
          tx_sh   <= {1'b1, status_q};
          tx_busy <= 1'b1;
          tx_cnt  <= '0;
          tx_bit  <= '0;
        end else if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            if (resp_left != 3'd0) begin
              txd_q     <= 1'b0;
              tx_sh     <= {1'b1, rd_q[DAT_W-1 -: 8]};
              tx_bit    <= '0;
              resp_left <= resp_left - 3'd1;
            end else begin
              tx_busy <= 1'b0;
            end
          end else begin
            txd_q  <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
            tx_bit <= tx_bit + 4'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign stb_o        = (p_state == P_BUS);
  assign cyc_o        = stb_o;
  assign sel_o        = {DAT_B{stb_o}};
  assign we_o         = stb_o & is_write;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
  assign rs232_txd_o  = txd_q;
  assign parser_state = p_state;

endmodule

// File: tb/tb_wb_uart_master.sv
module tb_wb_uart_master;

  localparam int CLK_DIV = 8;
  localparam int ADR_W   = 16;
  localparam int DAT_W   = 32;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              rxd = 1'b1;
  logic              txd;
  logic [ADR_W-1:0]  adr;
  logic [DAT_W-1:0]  dat_w;
  logic [DAT_W-1:0]  dat_r = '0;
  logic              we;
  logic [DAT_W/8-1:0] sel;
  logic              stb;
  logic              cyc;
  logic              ack = 1'b0;
  logic              err = 1'b0;
  logic [2:0]        pstate;

  wb_uart_master #(
    .CLK_DIV(CLK_DIV), .ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .rs232_rxd_i(rxd), .rs232_txd_o(txd),
    .adr_o(adr), .dat_o(dat_w), .dat_i(dat_r), .we_o(we), .sel_o(sel),
    .stb_o(stb), .cyc_o(cyc), .ack_i(ack), .err_i(err), .parser_state(pstate)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  // slv_mode: 0 silent, 1 ack, 2 err, 3 ack+err; responds once the strobe
  // has been high for slv_delay cycles.
  int          slv_mode = 0;
  int          slv_delay = 1;
  logic [31:0] slv_data = '0;
  int          hi_cnt = 0;
  int          last_hi = 0;
  int          bus_cnt = 0;
  logic [ADR_W-1:0]   cap_adr = '0;
  logic [DAT_W-1:0]   cap_dat = '0;
  logic               cap_we = 1'b0;
  logic [DAT_W/8-1:0] cap_sel = '0;
  logic               cap_cyc = 1'b0;
  logic               stable = 1'b1;
  logic               txd_at_fall = 1'b0;
  logic               txd_after = 1'b1;
  logic               fall_pending = 1'b0;

  always @(negedge clk) begin
    if (stb) begin
      if (hi_cnt == 0) begin
        bus_cnt++;
        cap_adr = adr; cap_dat = dat_w; cap_we = we; cap_sel = sel; cap_cyc = cyc;
        stable = 1'b1;
      end else if (adr !== cap_adr || dat_w !== cap_dat || we !== cap_we ||
                   sel !== cap_sel || cyc !== 1'b1) begin
        stable = 1'b0;
      end
      hi_cnt++;
      if (slv_mode != 0 && hi_cnt >= slv_delay) begin
        ack   = (slv_mode == 1 || slv_mode == 3);
        err   = (slv_mode == 2 || slv_mode == 3);
        dat_r = slv_data;
      end else begin
        ack = 1'b0; err = 1'b0;
      end
    end else begin
      ack = 1'b0; err = 1'b0;
      if (hi_cnt != 0) begin
        last_hi = hi_cnt; hi_cnt = 0;
        txd_at_fall = txd; fall_pending = 1'b1;
      end else if (fall_pending) begin
        txd_after = txd; fall_pending = 1'b0;
      end
    end
  end

  // ---------------- TX line monitor ----------------
  int tx_ferr = 0;
  always begin : tx_mon
    logic [7:0] b;
    @(negedge txd);
    repeat (CLK_DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      b[i] = txd;
    end
    repeat (CLK_DIV) @(negedge clk);
    if (txd !== 1'b1) tx_ferr++;
    got_q.push_back(b);
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rxd = good_stop;
    repeat (CLK_DIV) @(negedge clk);
    rxd = 1'b1;
    if (!good_stop) repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b [7], input int n);
    for (int i = 0; i < n; i++) send_byte(b[i], 1'b1);
  endtask

  task automatic wait_resp(input string tag);
    int n;
    int cyc_n;
    n = exp_q.size();
    cyc_n = 0;
    while (got_q.size() < n && cyc_n < 3000) begin
      @(negedge clk);
      cyc_n++;
    end
    check({tag, "_count"}, got_q.size(), n);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_stb(input string tag);
    int cyc_n;
    cyc_n = 0;
    while (stb !== 1'b1 && cyc_n < 300) begin
      @(negedge clk);
      cyc_n++;
    end
    check(tag, stb, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  int bc0;
  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_stb", stb, 1'b0);
    check("rst_cyc", cyc, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_sel", sel, 4'h0);
    check("rst_adr", adr, 16'h0);
    check("rst_dat", dat_w, 32'h0);
    check("rst_state", pstate, 3'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    got_q.delete();

    // Write 0x1234 <= 0xDEADBEEF, ack after 3 cycles
    slv_mode = 1; slv_delay = 3; bc0 = bus_cnt;
    txd_at_fall = 1'b0; txd_after = 1'b1;
    send_frame('{8'h57, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 7);
    exp_q.push_back(8'h06);
    wait_resp("wr_resp");
    check("wr_bus_cnt", bus_cnt, bc0 + 1);
    check("wr_adr", cap_adr, 16'h1234);
    check("wr_dat", cap_dat, 32'hDEADBEEF);
    check("wr_we", cap_we, 1'b1);
    check("wr_sel", cap_sel, 4'hF);
    check("wr_cyc", cap_cyc, 1'b1);
    check("wr_stable", stable, 1'b1);
    check("wr_hi_cycles", last_hi, 3);
    check("wr_txd_at_stb_fall", txd_at_fall, 1'b1);
    check("wr_txd_start_next", txd_after, 1'b0);

    // Read 0x0010, single-cycle ack with 0xCAFEF00D
    slv_mode = 1; slv_delay = 1; slv_data = 32'hCAFEF00D; bc0 = bus_cnt;
    send_frame('{8'h52, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    exp_q.push_back(8'h06); exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    wait_resp("rd_resp");
    check("rd_bus_cnt", bus_cnt, bc0 + 1);
    check("rd_adr", cap_adr, 16'h0010);
    check("rd_we", cap_we, 1'b0);
    check("rd_hi_cycles", last_hi, 1);
    repeat (2 * CLK_DIV) @(negedge clk);
    check("rd_txd_idle", txd, 1'b1);
    check("rd_state_idle", pstate, 3'd0);

    // Bus error: status only
    slv_mode = 2; slv_delay = 2; slv_data = 32'h99999999;
    send_frame('{8'h52, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    exp_q.push_back(8'h15);
    wait_resp("err_resp");
    repeat (45 * CLK_DIV) @(negedge clk);
    check("err_no_data", got_q.size(), 0);

    // ack and err together: ack wins
    slv_mode = 3; slv_delay = 1; slv_data = 32'h11223344;
    send_frame('{8'h52, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    exp_q.push_back(8'h06); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    wait_resp("both_resp");

    // Silent slave
    slv_mode = 0; slv_data = 32'h0BADCAFE;
    send_frame('{8'h52, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
`ifdef WB_UART_MASTER_TIMEOUT_EN
    exp_q.push_back(8'h18);
    wait_resp("tmo_resp");
    check("tmo_hi_cycles", last_hi, TIMEOUT);
    repeat (45 * CLK_DIV) @(negedge clk);
    check("tmo_no_data", got_q.size(), 0);
`else
    repeat (200) @(negedge clk);
    check("silent_stb_held", stb, 1'b1);
    check("silent_no_tx", got_q.size(), 0);
    slv_delay = 1; slv_mode = 1;
    exp_q.push_back(8'h06); exp_q.push_back(8'h0B); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    wait_resp("silent_resp");
    check("silent_long_cycle", last_hi >= 200, 1'b1);
`endif

    // Unknown command byte in IDLE
    slv_mode = 1; slv_delay = 1; bc0 = bus_cnt;
    send_byte(8'h41, 1'b1);
    repeat (40) @(negedge clk);
    check("junk_no_bus", bus_cnt, bc0);
    check("junk_no_tx", got_q.size(), 0);

    // Frame error in an address byte, then a clean write
    bc0 = bus_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_no_bus", bus_cnt, bc0);
    check("ferr_state_idle", pstate, 3'd0);
    slv_delay = 2;
    send_frame('{8'h57, 8'hAB, 8'hCD, 8'h01, 8'h02, 8'h03, 8'h04}, 7);
    exp_q.push_back(8'h06);
    wait_resp("ferr_next_resp");
    check("ferr_next_bus_cnt", bus_cnt, bc0 + 1);
    check("ferr_next_adr", cap_adr, 16'hABCD);
    check("ferr_next_dat", cap_dat, 32'h01020304);

    // Command bytes during RESP are ignored
    slv_delay = 1; slv_data = 32'h55AA1234; bc0 = bus_cnt;
    send_frame('{8'h52, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    send_frame('{8'h52, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    exp_q.push_back(8'h06); exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    wait_resp("resp_busy_resp");
    repeat (30 * CLK_DIV) @(negedge clk);
    check("resp_busy_bus_cnt", bus_cnt, bc0 + 1);
    check("resp_busy_no_extra", got_q.size(), 0);

    // Reset during BUS
    slv_mode = 0;
    send_frame('{8'h52, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    wait_stb("rstbus_stb_seen");
    rst_n = 1'b0;
    #1;
    check("rstbus_stb", stb, 1'b0);
    check("rstbus_cyc", cyc, 1'b0);
    check("rstbus_sel", sel, 4'h0);
    check("rstbus_txd", txd, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset mid-transmit, inside data bit 0 of status 0x06 (a low bit)
    slv_mode = 1; slv_delay = 1; slv_data = 32'hA5A5A5A5;
    send_frame('{8'h52, 8'h00, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    begin
      int w;
      w = 0;
      while (txd !== 1'b0 && w < 300) begin
        @(negedge clk);
        w++;
      end
    end
    repeat (CLK_DIV + CLK_DIV / 2) @(negedge clk);
    check("rsttx_line_low_before", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rsttx_txd", txd, 1'b1);
    check("rsttx_stb", stb, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CLK_DIV) @(negedge clk);
    got_q.delete();
    exp_q.delete();

    // Write after reset
    slv_delay = 2; bc0 = bus_cnt;
    send_frame('{8'h57, 8'h00, 8'h60, 8'h12, 8'h34, 8'h56, 8'h78}, 7);
    exp_q.push_back(8'h06);
    wait_resp("post_rst_resp");
    check("post_rst_bus_cnt", bus_cnt, bc0 + 1);
    check("post_rst_adr", cap_adr, 16'h0060);
    check("post_rst_dat", cap_dat, 32'h12345678);
    check("post_rst_we", cap_we, 1'b1);
    check("post_rst_hi_cycles", last_hi, 2);

    repeat (4 * CLK_DIV) @(negedge clk);
    check("tx_stop_bits", tx_ferr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
